ber_scan_controller: RTL
========================

BER_SCAN_CONTROLLER -- requirements
Module: ber_scan_controller

Interface
REQ-001 Parameter NUM_CH, default 8: number of generator/checker channels scanned, 1..16.
REQ-002 Parameter PULSE_LEN, default 64: clear-pulse length in clock cycles; must cover at least one 5 MHz checker edge (clock/32).
REQ-003 clock  in  1  160 MHz bit clock shared with the generator/checker.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  single-cycle scan request.
REQ-006 abort  in  1  single-cycle scan cancel.
REQ-007 ch_mask  in  NUM_CH  channel enable, bit i = channel i.
REQ-008 settle  in  16  wait cycles after the clear pulse.
REQ-009 dwell  in  32  measurement window in cycles; 0 is treated as 1.
REQ-010 err_count_in  in  64  error count of the currently selected channel.
REQ-011 err_threshold  in  64  stop threshold, used only with SCAN_STOP_ON_ERROR_EN.
REQ-012 channel  out  4  selected channel index.
REQ-013 pulse  out  1  counter clear/restart strobe to the checker.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 res_valid/res_ready  out/in  1/1  result handshake.
REQ-016 res_channel  out  4  channel of the presented result.
REQ-017 res_count  out  64  captured error count.
REQ-018 done  out  1  single-cycle scan-complete strobe.
REQ-019 err_stop  out  1  high when the scan ended on the threshold; held until the next start.

Function
REQ-020 The FSM shall have states IDLE, SELECT, CLEAR, SETTLE, DWELL, CAPTURE, REPORT and DONE.
REQ-021 IDLE, start=1, ch_mask!=0: go to SELECT with the search index at 0; with ch_mask=0, go directly to DONE and emit no results.
REQ-022 SELECT (1 cycle): set channel to the lowest enabled index >= search index, then go to CLEAR.
REQ-023 CLEAR: drive pulse=1 for exactly PULSE_LEN cycles, then go to SETTLE with pulse=0.
REQ-024 SETTLE: stay exactly settle cycles (0 means 0 cycles), then go to DWELL.
REQ-025 DWELL: stay exactly max(dwell,1) cycles, then go to CAPTURE.
REQ-026 CAPTURE (1 cycle): register err_count_in into res_count and channel into res_channel; go to REPORT.
REQ-027 REPORT: hold res_valid=1 with stable res_count and res_channel until the cycle res_valid&res_ready; never drop valid without a transfer or abort.
REQ-028 After the transfer: if any enabled channel exists above the current one, go to SELECT with search index = current+1; otherwise go to DONE.
REQ-029 DONE (1 cycle): done=1, then IDLE.
REQ-030 ch_mask, settle, dwell and err_threshold shall be sampled at start and held for the whole scan.
REQ-031 start while busy shall be ignored.
REQ-032 abort in any non-IDLE state: next cycle IDLE, pulse=0, res_valid=0, no done strobe; abort has priority over start and over a same-cycle transfer.
REQ-033 channel shall hold its last value in IDLE.
REQ-034 All cycle counters shall be wide enough that no wrap occurs for maximum settle/dwell.

Reset
REQ-035 On reset: state IDLE; channel=0, pulse=0, busy=0, res_valid=0, res_channel=0, res_count=0, done=0, err_stop=0.
REQ-036 Reset asserted mid-scan shall abandon the scan with no done strobe.

Configuration
REQ-037 With SCAN_STOP_ON_ERROR_EN defined: after a REPORT transfer with res_count > sampled err_threshold, go to DONE, set err_stop=1 and skip the remaining channels.
REQ-038 Without SCAN_STOP_ON_ERROR_EN: err_threshold is ignored, err_stop is tied to 0, and every enabled channel is scanned.

Verification
REQ-039 ch_mask=8'b0000_0101, settle=10, dwell=100, res_ready=1: results are channel 0 then channel 2; pulse is 64 cycles wide per channel; done fires once.
REQ-040 res_ready=0 for 20 cycles in REPORT: res_valid stays high and res_count is stable throughout; transfer happens on the first ready cycle.
REQ-041 ch_mask=0 with start: done fires 1 cycle later, res_valid never asserts.
REQ-042 abort during DWELL of channel 1: IDLE the next cycle, busy=0, done never asserts; a new start rescans from channel 0.
REQ-043 SCAN_STOP_ON_ERROR_EN defined, err_threshold=5, ch1 count=9, mask=8'hFF: results are ch0 and ch1 only, then done=1 and err_stop=1.
REQ-044 reset pulse during CLEAR: pulse drops asynchronously and all outputs take their REQ-035 values.

Source files
------------

// File: rtl/ber_scan_controller.sv
// BER scan controller: walks the enabled generator/checker channels, clears and
// restarts each checker, waits settle + dwell cycles and hands the captured error
// count out over a valid/ready result port.
// Optional feature: define SCAN_STOP_ON_ERROR_EN to end the scan early on the
// first result whose count exceeds the sampled err_threshold.
module ber_scan_controller #(
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned PULSE_LEN = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [15:0]       settle,
   input  logic [31:0]       dwell,
   input  logic [63:0]       err_count_in,
   input  logic [63:0]       err_threshold,
   output logic [3:0]        channel,
   output logic              pulse,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [3:0]        res_channel,
   output logic [63:0]       res_count,
   output logic              done,
   output logic              err_stop
);

   localparam int unsigned CNT_W = 32;
   localparam int unsigned CH_W  = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_CLEAR, S_SETTLE, S_DWELL, S_CAPTURE, S_REPORT, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CH_W-1:0]   search_idx, search_nxt;
   logic [CH_W-1:0]   channel_nxt, res_channel_nxt;
   logic [63:0]       res_count_nxt;
   logic [NUM_CH-1:0] mask_q, mask_nxt;
   logic [15:0]       settle_q, settle_nxt;
   logic [31:0]       dwell_q, dwell_nxt;
   logic [CH_W-1:0]   sel_ch;
   logic              more_above;
`ifdef SCAN_STOP_ON_ERROR_EN
   logic [63:0]       thr_q, thr_nxt;
   logic              err_stop_nxt;
`else
   logic              unused_thr;
   assign unused_thr = ^err_threshold;
   assign err_stop   = 1'b0;
`endif

   // Lowest enabled channel at or above the search index.
   always_comb begin
      sel_ch = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (mask_q[i] && (i >= int'(search_idx))) sel_ch = CH_W'(i);
      end
   end

   // Any enabled channel above the one currently selected.
   always_comb begin
      more_above = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (mask_q[i] && (i > int'(channel))) more_above = 1'b1;
      end
   end

   // Next-state and next-value logic for the scan sequence.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      search_nxt      = search_idx;
      channel_nxt     = channel;
      res_channel_nxt = res_channel;
      res_count_nxt   = res_count;
      mask_nxt        = mask_q;
      settle_nxt      = settle_q;
      dwell_nxt       = dwell_q;
`ifdef SCAN_STOP_ON_ERROR_EN
      thr_nxt         = thr_q;
      err_stop_nxt    = err_stop;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               mask_nxt   = ch_mask;
               settle_nxt = settle;
               dwell_nxt  = (dwell == 32'd0) ? 32'd1 : dwell;
               search_nxt = '0;
               cnt_nxt    = '0;
`ifdef SCAN_STOP_ON_ERROR_EN
               thr_nxt      = err_threshold;
               err_stop_nxt = 1'b0;
`endif
               state_nxt  = (ch_mask == '0) ? S_DONE : S_SELECT;
            end
         end
         S_SELECT: begin
            channel_nxt = sel_ch;
            cnt_nxt     = '0;
            state_nxt   = S_CLEAR;
         end
         S_CLEAR: begin
            if (cnt == CNT_W'(PULSE_LEN - 1)) begin
               cnt_nxt   = '0;
               state_nxt = (settle_q == 16'd0) ? S_DWELL : S_SETTLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_SETTLE: begin
            if (cnt == CNT_W'(settle_q) - CNT_W'(1)) begin
               cnt_nxt   = '0;
               state_nxt = S_DWELL;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_DWELL: begin
            if (cnt == dwell_q - CNT_W'(1)) begin
               cnt_nxt   = '0;
               state_nxt = S_CAPTURE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_CAPTURE: begin
            res_count_nxt   = err_count_in;
            res_channel_nxt = channel;
            state_nxt       = S_REPORT;
         end
         S_REPORT: begin
            if (res_ready) begin
`ifdef SCAN_STOP_ON_ERROR_EN
               if (res_count > thr_q) begin
                  err_stop_nxt = 1'b1;
                  state_nxt    = S_DONE;
               end else
`endif
               if (more_above) begin
                  search_nxt = channel + CH_W'(1);
                  state_nxt  = S_SELECT;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Abort wins over everything, including a same-cycle transfer.
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
`ifdef SCAN_STOP_ON_ERROR_EN
         err_stop_nxt = err_stop;
`endif
      end
   end

   // State register plus registered outputs derived from the next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         search_idx  <= '0;
         channel     <= '0;
         res_channel <= '0;
         res_count   <= '0;
         mask_q      <= '0;
         settle_q    <= '0;
         dwell_q     <= 32'd1;
         pulse       <= 1'b0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         done        <= 1'b0;
`ifdef SCAN_STOP_ON_ERROR_EN
         thr_q       <= '0;
         err_stop    <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         search_idx  <= search_nxt;
         channel     <= channel_nxt;
         res_channel <= res_channel_nxt;
         res_count   <= res_count_nxt;
         mask_q      <= mask_nxt;
         settle_q    <= settle_nxt;
         dwell_q     <= dwell_nxt;
         pulse       <= (state_nxt == S_CLEAR);
         busy        <= (state_nxt != S_IDLE);
         res_valid   <= (state_nxt == S_REPORT);
         done        <= (state_nxt == S_DONE);
`ifdef SCAN_STOP_ON_ERROR_EN
         thr_q       <= thr_nxt;
         err_stop    <= err_stop_nxt;
`endif
      end
   end

endmodule
